// File: rtl/flash_store_pkg.sv
// Shared definitions for the flash-side credential record store.
package flash_store_pkg;

    localparam int DATA_W_DEF = 256;
    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH_DEF  = 16;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_ERASE = 2'd2
    } state_t;

endpackage

// File: rtl/valid_hwm_enc.sv
// Priority encoder: highest set bit of the valid bitmap, plus an all-clear flag.
module valid_hwm_enc #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic [DEPTH-1:0]  i_valid,
    output logic [ADDR_W-1:0] o_max_address,
    output logic              o_empty
);

    always_comb begin
        o_max_address = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i_valid[i]) begin
                o_max_address = ADDR_W'(i);
            end
        end
    end

    assign o_empty = ~|i_valid;

endmodule

// File: rtl/flash_store.sv
// Record store answering the vault initiator: 1-cycle reads, high-water mark,
// power-up clear and bulk-erase sweep, sticky dropped-write flag.
module flash_store
    import flash_store_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] add_flash,
    input  logic              flash_write,
    input  logic [DATA_W-1:0] write_data_flash,
    input  logic              erase_all,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_flash,
    output logic [ADDR_W-1:0] max_address,
    output logic              flash_empty,
    output logic              flash_busy,
    output logic              wr_err
);

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_cnt;
    logic [DEPTH-1:0]   r_valid;
    logic [DATA_W-1:0]  r_data;
    logic               r_err;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_busy;
    logic               w_addr_ok;
    logic               w_wr_ok;
    logic               w_sweep_last;

    assign w_busy       = (r_state != S_IDLE);
    assign w_addr_ok    = (32'(add_flash) < 32'(DEPTH));
    assign w_wr_ok      = flash_write & ~w_busy & w_addr_ok;
    assign w_sweep_last = (r_cnt == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT, S_ERASE: if (w_sweep_last) w_next = S_IDLE;
            S_IDLE:          if (erase_all)    w_next = S_ERASE;
            default:         w_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= w_sweep_last ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_busy) begin
            r_valid[r_cnt] <= 1'b0;
        end else if (w_wr_ok) begin
            r_valid[add_flash] <= 1'b1;
        end
    end

    // Storage has no reset; the INIT sweep zeroes it before it can be read.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_ok) begin
            r_mem[add_flash] <= write_data_flash;
        end
    end

    // Write-first: a write in IDLE is returned on the same read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (w_busy || !w_addr_ok) begin
            r_data <= '0;
        end else if (flash_write) begin
            r_data <= write_data_flash;
        end else begin
            r_data <= r_mem[add_flash];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (flash_write && (w_busy || !w_addr_ok)) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    valid_hwm_enc #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_hwm (
        .i_valid       (r_valid),
        .o_max_address (max_address),
        .o_empty       (flash_empty)
    );

    assign data_flash = r_data;
    assign flash_busy = w_busy;
    assign wr_err     = r_err;

endmodule

// File: tb/tb_flash_store.sv
// Randomised and directed checking of flash_store against a behavioural model.
module tb_flash_store;

    localparam int DW = 256;
    localparam int AW = 4;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] add_flash;
    logic          flash_write;
    logic [DW-1:0] write_data_flash;
    logic          erase_all;
    logic          err_clr;
    logic [DW-1:0] data_flash;
    logic [AW-1:0] max_address;
    logic          flash_empty;
    logic          flash_busy;
    logic          wr_err;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_mem [DP];
    bit            m_valid [DP];
    int            m_busy_left;
    logic [DW-1:0] m_data;
    bit            m_err;

    flash_store #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .add_flash        (add_flash),
        .flash_write      (flash_write),
        .write_data_flash (write_data_flash),
        .erase_all        (erase_all),
        .err_clr          (err_clr),
        .data_flash       (data_flash),
        .max_address      (max_address),
        .flash_empty      (flash_empty),
        .flash_busy       (flash_busy),
        .wr_err           (wr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int model_max();
        int m = 0;
        for (int i = 0; i < DP; i++) if (m_valid[i]) m = i;
        return m;
    endfunction

    function automatic bit model_empty();
        for (int i = 0; i < DP; i++) if (m_valid[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic compare_outputs();
        chk("data_flash",  data_flash, m_data);
        chk("max_address", DW'(max_address), DW'(model_max()));
        chk("flash_empty", DW'(flash_empty), DW'(model_empty()));
        chk("flash_busy",  DW'(flash_busy),  DW'(m_busy_left > 0));
        chk("wr_err",      DW'(wr_err),      DW'(m_err));
    endtask

    task automatic step(input bit wr, input int a, input logic [DW-1:0] d,
                        input bit er, input bit ec);
        bit busy;
        bit aok;
        int idx;
        flash_write      = wr;
        add_flash        = AW'(a);
        write_data_flash = d;
        erase_all        = er;
        err_clr          = ec;
        @(posedge clk);
        busy   = (m_busy_left > 0);
        aok    = (a < DP);
        m_data = (busy || !aok) ? '0 : (wr ? d : m_mem[a]);
        if (wr && (busy || !aok)) m_err = 1'b1;
        else if (ec)              m_err = 1'b0;
        if (busy) begin
            idx = DP - m_busy_left;
            m_mem[idx]   = '0;
            m_valid[idx] = 1'b0;
            m_busy_left--;
        end else begin
            if (wr && aok) begin
                m_mem[a]   = d;
                m_valid[a] = 1'b1;
            end
            if (er) m_busy_left = DP;
        end
        #1;
        compare_outputs();
    endtask

    task automatic idle(input int a);
        step(1'b0, a, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        flash_write = 1'b0;
        erase_all   = 1'b0;
        err_clr     = 1'b0;
        rst         = 1'b1;
        #1;
        m_busy_left = DP;
        m_data      = '0;
        m_err       = 1'b0;
        for (int i = 0; i < DP; i++) m_valid[i] = 1'b0;
        chk("rst data",  data_flash, '0);
        chk("rst max",   DW'(max_address), '0);
        chk("rst empty", DW'(flash_empty), DW'(1));
        chk("rst busy",  DW'(flash_busy),  DW'(1));
        chk("rst err",   DW'(wr_err),      '0);
        repeat (2) @(posedge clk);
        #1;
        compare_outputs();
        rst = 1'b0;
    endtask

    // Counts busy cycles from the current sample until IDLE, bounded.
    task automatic count_busy(input string nm);
        int nb = flash_busy ? 1 : 0;
        for (int i = 0; i < 40 && flash_busy; i++) begin
            idle(i % DP);
            if (flash_busy) nb++;
        end
        chk(nm, DW'(nb), DW'(DP));
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        logic [DW-1:0] a5;
        logic [DW-1:0] d2, d4, d9;
        int nb;
        for (int i = 0; i < DP; i++) m_mem[i] = '0;
        for (int k = 0; k < DW / 8; k++) a5[k*8 +: 8] = 8'hA5;
        d2 = rnd_data();
        d4 = rnd_data();
        d9 = rnd_data();
        add_flash        = '0;
        write_data_flash = '0;

        // Power-up sweep
        do_reset();
        count_busy("init busy cycles");

        // Store then read back
        step(1'b1, 3, a5, 1'b0, 1'b0);
        chk("max after wr3", DW'(max_address), DW'(3));
        chk("empty after wr3", DW'(flash_empty), '0);
        idle(3);
        chk("read3", data_flash, a5);

        step(1'b1, 5, DW'(16'h1234), 1'b0, 1'b0);
        chk("bypass5", data_flash, DW'(16'h1234));

        step(1'b1, 2, d2, 1'b0, 1'b0);
        step(1'b1, 9, d9, 1'b0, 1'b0);
        chk("max after wr9", DW'(max_address), DW'(9));
        step(1'b1, 4, d4, 1'b0, 1'b0);
        chk("max after wr4", DW'(max_address), DW'(9));
        idle(2);
        chk("read2", data_flash, d2);
        idle(4);
        chk("read4", data_flash, d4);
        idle(9);
        chk("read9", data_flash, d9);

        // Bulk erase with a write attempted mid-sweep
        step(1'b0, 0, '0, 1'b1, 1'b0);
        nb = flash_busy ? 1 : 0;
        for (int i = 0; i < 40 && flash_busy; i++) begin
            if (i == 3) begin
                step(1'b1, 7, rnd_data(), 1'b0, 1'b0);
                chk("wr_err on busy write", DW'(wr_err), DW'(1));
            end else begin
                idle(0);
            end
            if (flash_busy) nb++;
        end
        chk("erase busy cycles", DW'(nb), DW'(DP));
        chk("max after erase", DW'(max_address), '0);
        chk("empty after erase", DW'(flash_empty), DW'(1));
        idle(7);
        chk("read7 after erase", data_flash, '0);
        idle(9);
        chk("read9 after erase", data_flash, '0);
        step(1'b0, 0, '0, 1'b0, 1'b1);
        chk("err_clr", DW'(wr_err), '0);

        step(1'b1, 3, a5, 1'b1, 1'b0);
        step(1'b1, 7, rnd_data(), 1'b0, 1'b1);
        chk("set beats clear", DW'(wr_err), DW'(1));
        for (int i = 0; i < 3; i++) idle(i);

        // Reset in the middle of the sweep
        do_reset();
        count_busy("reinit busy cycles");
        step(1'b1, 11, d9, 1'b0, 1'b0);
        idle(11);
        chk("read11 after reinit", data_flash, d9);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            bit wr = ($urandom_range(0, 99) < 35);
            bit er = ($urandom_range(0, 99) < 2);
            bit ec = ($urandom_range(0, 99) < 10);
            step(wr, $urandom_range(0, DP - 1), rnd_data(), er, ec);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
